// File: rtl/cpu_jtag_debug_cmd_queue_if.sv
// rtl/cpu_jtag_debug_cmd_queue_if.sv - command delivery handshake between the queue and the debug core
// Ports (master = queue side):
//   cmd_valid      : queue holds a command
//   cmd_ready      : consumer accepts the head command
//   cmd_ir / jdo   : head instruction and data word
//   take_action    : one-hot per-instruction action strobe, valid in the pop cycle
//   take_no_action : one-hot per-instruction no-action strobe, valid in the pop cycle
interface cpu_jtag_debug_cmd_queue_if #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [IR_W-1:0]      cmd_ir;
  logic [DR_W-1:0]      jdo;
  logic [2**IR_W-1:0]   take_action;
  logic [2**IR_W-1:0]   take_no_action;

  modport master (
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_jtag_debug_cmd_queue.sv
// rtl/cpu_jtag_debug_cmd_queue.sv - clk-side JTAG debug command receiver and queue
// Ports:
//   clk, reset_n   : system clock, asynchronous active-low reset
//   ir_in, sr      : TCK-domain instruction and shift register (quasi-static)
//   vs_udr, vs_uir : TCK-domain update-DR / update-IR levels
//   clr_overflow   : clears the sticky overflow flag
//   cmd            : command handshake interface (master side)
//   uir_pulse      : one-cycle strobe per synchronised update-IR
//   fill_level     : number of queued commands
//   overflow       : sticky, set when a command is dropped on a full queue
module cpu_jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = 35
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [DR_W-1:0]                 sr,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic                            clr_overflow,
  cpu_jtag_debug_cmd_queue_if.master      cmd,
  output logic                            uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = IR_W + DR_W;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_hist;
  logic                   r_uir_hist;
  logic                   r_uir_pulse;
  logic                   r_overflow;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [EW-1:0]          r_mem [FIFO_DEPTH];

  logic                   w_udr_rise;
  logic                   w_uir_rise;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [EW-1:0]          w_head;

  assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
  assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop      = cmd.cmd_valid & cmd.cmd_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_udr_rise & (~w_full | w_pop);
  assign w_drop     = w_udr_rise & w_full & ~w_pop;
  assign w_head     = r_mem[r_rd_ptr];

  assign cmd.cmd_valid = (r_count != '0);
  assign cmd.cmd_ir    = w_head[EW-1:DR_W];
  assign cmd.jdo       = w_head[DR_W-1:0];
  assign uir_pulse     = r_uir_pulse;
  assign fill_level    = r_count;
  assign overflow      = r_overflow;

  always_comb begin
    cmd.take_action    = '0;
    cmd.take_no_action = '0;
    for (int k = 0; k < 2**IR_W; k++) begin
      if (w_pop && cmd.cmd_ir == IR_W'(k)) begin
        cmd.take_action[k]    = cmd.jdo[ACTION_BIT];
        cmd.take_no_action[k] = ~cmd.jdo[ACTION_BIT];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_udr_hist  <= 1'b0;
      r_uir_hist  <= 1'b0;
      r_uir_pulse <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_hist  <= r_udr_sync[SYNC_STAGES-1];
      r_uir_hist  <= r_uir_sync[SYNC_STAGES-1];
      r_uir_pulse <= w_uir_rise;

      // Set has priority over clear so a drop is never hidden.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;

      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {ir_in, sr};
  end
endmodule

// File: tb/tb_cpu_jtag_debug_cmd_queue.sv
// tb/tb_cpu_jtag_debug_cmd_queue.sv - self-checking bench for cpu_jtag_debug_cmd_queue
module tb_cpu_jtag_debug_cmd_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr;
  logic        vs_uir;
  logic        clr_overflow;
  logic        uir_pulse;
  logic [2:0]  fill_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [39:0] sb[$];
  logic        exp_ovf = 1'b0;

  cpu_jtag_debug_cmd_queue_if #(.IR_W(2), .DR_W(38)) cmd_bus ();

  cpu_jtag_debug_cmd_queue dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .clr_overflow (clr_overflow),
    .cmd          (cmd_bus.master),
    .uir_pulse    (uir_pulse),
    .fill_level   (fill_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk_dr(input logic act, input logic [31:0] lo);
    logic [37:0] d;
    d = {6'b0, lo};
    d[35] = act;
    return d;
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if (cmd_bus.cmd_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b0 ||
        uir_pulse !== 1'b0 || cmd_bus.take_action !== 4'b0 || cmd_bus.take_no_action !== 4'b0) begin
      errors++;
      $display("FAIL %s: valid=%b fill=%0d ovf=%b uir=%b ta=%b tna=%b, required all zero",
               name, cmd_bus.cmd_valid, fill_level, overflow, uir_pulse,
               cmd_bus.take_action, cmd_bus.take_no_action);
    end
  endtask

  // One udr pulse sampled at exactly one edge; checks latency and fill level.
  task automatic do_scan(input logic [1:0] ir, input logic [37:0] d);
    int n0;
    n0 = sb.size();
    ir_in = ir; sr = d; vs_udr = 1'b1;
    @(posedge clk); #1; vs_udr = 1'b0;            // edge 0
    @(posedge clk); #1;                           // edge 1
    checks++;
    if (fill_level !== 3'(n0)) begin
      errors++;
      $display("FAIL scan_lat_e1: fill=%0d required %0d", fill_level, n0);
    end
    @(posedge clk); #1;                           // edge 2: push lands
    if (n0 < 4) sb.push_back({ir, d});
    else exp_ovf = 1'b1;
    checks++;
    if (fill_level !== 3'(sb.size()) || cmd_bus.cmd_valid !== 1'b1 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL scan_e2: fill=%0d valid=%b ovf=%b required fill=%0d valid=1 ovf=%b",
               fill_level, cmd_bus.cmd_valid, overflow, sb.size(), exp_ovf);
    end
    @(posedge clk); #1;                           // history flop settles
  endtask

  // Pop the head, compare it and its strobes against the scoreboard front.
  task automatic pop_one(input string name);
    logic [39:0] e;
    logic [3:0]  ea, en;
    checks++;
    if (cmd_bus.cmd_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_valid: valid=%b model_entries=%0d required valid=1 with an entry",
               name, cmd_bus.cmd_valid, sb.size());
      return;
    end
    e  = sb.pop_front();
    ea = e[35] ? (4'b0001 << e[39:38]) : 4'b0;
    en = e[35] ? 4'b0 : (4'b0001 << e[39:38]);
    cmd_bus.cmd_ready = 1'b1;
    #1;
    checks++;
    if (cmd_bus.cmd_ir !== e[39:38] || cmd_bus.jdo !== e[37:0] ||
        cmd_bus.take_action !== ea || cmd_bus.take_no_action !== en) begin
      errors++;
      $display("FAIL %s_head: ir=%0d jdo=%h ta=%b tna=%b required ir=%0d jdo=%h ta=%b tna=%b",
               name, cmd_bus.cmd_ir, cmd_bus.jdo, cmd_bus.take_action, cmd_bus.take_no_action,
               e[39:38], e[37:0], ea, en);
    end
    @(posedge clk); #1;
    cmd_bus.cmd_ready = 1'b0;
    #1;
    checks++;
    if (cmd_bus.take_action !== 4'b0 || cmd_bus.take_no_action !== 4'b0 ||
        fill_level !== 3'(sb.size())) begin
      errors++;
      $display("FAIL %s_after: ta=%b tna=%b fill=%0d required 0 0 %0d",
               name, cmd_bus.take_action, cmd_bus.take_no_action, fill_level, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    clr_overflow = 1'b0; cmd_bus.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset");
  endtask

  task automatic test_action();
    do_scan(2'd2, mk_dr(1'b1, 32'hDEADBEEF));
    pop_one("action");
    checks++;
    if (cmd_bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL action_empty: valid=%b required 0", cmd_bus.cmd_valid);
    end
  endtask

  task automatic test_no_action();
    do_scan(2'd0, mk_dr(1'b0, 32'hDEADBEEF));
    pop_one("no_action");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++)
      do_scan(2'(i % 4), mk_dr(i[0], 32'h1000 + i));
    checks++;
    if (fill_level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: fill=%0d ovf=%b required 4 1", fill_level, overflow);
    end
    for (int i = 0; i < 4; i++) pop_one("ovf_drain");
    checks++;
    if (cmd_bus.cmd_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: valid=%b ovf=%b required 0 1", cmd_bus.cmd_valid, overflow);
    end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    exp_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] e;
    logic [3:0]  ea;
    for (int i = 0; i < 4; i++) do_scan(2'(3 - i), mk_dr(1'b1, 32'hA000 + i));
    // Push arrives on a full queue in the same cycle as a pop.
    ir_in = 2'd1; sr = mk_dr(1'b0, 32'hCAFE0001); vs_udr = 1'b1;
    @(posedge clk); #1; vs_udr = 1'b0;
    @(posedge clk); #1;
    cmd_bus.cmd_ready = 1'b1;
    #1;
    e  = sb.pop_front();
    ea = 4'b0001 << e[39:38];
    checks++;
    if (cmd_bus.take_action !== ea || cmd_bus.cmd_ir !== e[39:38] || cmd_bus.jdo !== e[37:0]) begin
      errors++;
      $display("FAIL b2b_pop: ta=%b ir=%0d jdo=%h required ta=%b ir=%0d jdo=%h",
               cmd_bus.take_action, cmd_bus.cmd_ir, cmd_bus.jdo, ea, e[39:38], e[37:0]);
    end
    @(posedge clk); #1;
    cmd_bus.cmd_ready = 1'b0;
    sb.push_back({2'd1, mk_dr(1'b0, 32'hCAFE0001)});
    checks++;
    if (fill_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: fill=%0d ovf=%b required 4 0", fill_level, overflow);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) pop_one("b2b_drain");
    for (int i = 0; i < 8; i++) begin
      do_scan(2'(i), mk_dr(i[1], 32'h5000 + i));
      pop_one("wrap");
    end
  endtask

  task automatic test_held_levels();
    int pulses;
    int at;
    pulses = 0; at = -1;
    vs_uir = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 9) vs_uir = 1'b0;
      if (uir_pulse === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    checks++;
    if (pulses != 1 || at != 2 || cmd_bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL uir_held: pulses=%0d first_edge=%0d valid=%b required 1 2 0",
               pulses, at, cmd_bus.cmd_valid);
    end
    ir_in = 2'd3; sr = mk_dr(1'b1, 32'h77777777); vs_udr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 9) vs_udr = 1'b0;
    end
    sb.push_back({2'd3, mk_dr(1'b1, 32'h77777777)});
    checks++;
    if (fill_level !== 3'd1) begin
      errors++;
      $display("FAIL udr_held: fill=%0d required 1", fill_level);
    end
    pop_one("udr_held");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_scan(2'(i), mk_dr(1'b1, 32'h9000 + i));
    ir_in = 2'd2; sr = mk_dr(1'b1, 32'h12345678); vs_udr = 1'b1;
    @(posedge clk); #1;
    vs_udr = 1'b0;
    reset_n = 1'b0;
    #1;
    sb.delete();
    exp_ovf = 1'b0;
    check_idle_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_idle_outputs("reset_after");
  endtask

  initial begin
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_back_to_back();
    test_held_levels();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
